// File: rtl/infetch_queue.sv
// infetch_queue: instruction fetch unit with a single outstanding memory
// request, a DEPTH-entry instruction queue toward decode, redirect/halt
// control and a sticky misaligned-redirect error.
// Optional feature: define INFETCH_BYPASS_EN to let a response arriving at
// an empty queue drive the decode outputs in the same cycle as imem_ack.
module infetch_queue #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter int               INC      = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc2,
  output logic             err
);

  localparam int               PW      = $clog2(DEPTH);
  localparam int               CW      = PW + 1;
  localparam logic [CW-1:0]    L_DEPTH = CW'(DEPTH);
  localparam logic [WIDTH-1:0] L_INC   = WIDTH'(INC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_squash;
  logic             w_squash_nxt;
  logic             r_err;
  logic [WIDTH-1:0] r_pc;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;

  // Queue storage (data only, never reset)
  logic [WIDTH-1:0] r_q_instr [DEPTH];
  logic [WIDTH-1:0] r_q_pc2   [DEPTH];

  logic             w_ack_ok;
  logic             w_resp;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_misalign;
  logic             w_err_nxt;
  logic             w_byp;
  logic             w_byp_take;
  logic             w_nonempty;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;

  // A response only counts while waiting; a squashed one carries stale data.
  assign w_ack_ok   = (r_state == S_WAIT) && imem_ack;
  assign w_resp     = w_ack_ok && !r_squash;
  assign w_pc_inc   = r_pc + L_INC;
  assign w_misalign = redirect && redirect_pc[0];
  assign w_err_nxt  = r_err || w_misalign;
  assign w_nonempty = (r_count != '0);

`ifdef INFETCH_BYPASS_EN
  assign w_byp      = !w_nonempty && w_resp && !redirect;
  assign w_byp_take = w_byp && out_ready;
`else
  assign w_byp      = 1'b0;
  assign w_byp_take = 1'b0;
`endif

  // Redirect overrides both ends of the queue in the same cycle.
  assign w_pop  = w_nonempty && out_ready && !redirect;
  assign w_push = w_resp && !redirect && !w_byp_take;

  // Occupancy after this cycle's push/pop; the issue check uses it so the
  // one outstanding response always has a free slot waiting for it.
  always_comb begin
    w_count_nxt = r_count;
    if (redirect) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  assign w_issue = !halt && !w_err_nxt && (w_count_nxt < L_DEPTH);

  // Next-state and squash logic for the request FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_squash_nxt = r_squash;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // The request is accepted on this edge; a redirect makes it stale.
        w_state_nxt = S_WAIT;
        if (redirect) w_squash_nxt = 1'b1;
      end
      S_WAIT: begin
        if (imem_ack) begin
          // The outstanding request retires, so nothing is left to squash.
          w_squash_nxt = 1'b0;
          w_state_nxt  = w_issue ? S_REQ : S_IDLE;
        end else if (redirect) begin
          w_squash_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_squash_nxt = 1'b0;
      end
    endcase
  end

  // Control state: FSM, PC, error flag and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_squash <= 1'b0;
      r_err    <= 1'b0;
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_squash <= w_squash_nxt;
      r_err    <= w_err_nxt;
      r_count  <= w_count_nxt;
      if (redirect) begin
        r_pc   <= redirect_pc;
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_resp) r_pc <= w_pc_inc;
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // Queue write port: instruction paired with its sequential successor PC.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= imem_rdata;
      r_q_pc2[r_wptr]   <= w_pc_inc;
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign err       = r_err;
  assign out_valid = w_nonempty || w_byp;

  // Head selection; outputs read zero while nothing is valid.
  always_comb begin
    out_instr = '0;
    out_pc2   = '0;
    if (w_nonempty) begin
      out_instr = r_q_instr[r_rptr];
      out_pc2   = r_q_pc2[r_rptr];
    end else if (w_byp) begin
      out_instr = imem_rdata;
      out_pc2   = w_pc_inc;
    end
  end

endmodule

// File: tb/tb_infetch_queue.sv
// Directed testbench for infetch_queue (default build, bypass disabled).
module tb_infetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc2;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  infetch_queue #(.WIDTH(16), .DEPTH(4), .INC(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc2(out_pc2), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: ack 'lat' cycles after acceptance; hold_en stalls one address.
  int          lat = 1;
  logic        hold_en = 1'b0;
  logic [15:0] hold_addr = 16'h0;
  logic        mem_pend;
  logic [15:0] mem_addr;
  int          mem_cnt;

  assign imem_ack   = mem_pend && (mem_cnt == 1) && !(hold_en && (mem_addr == hold_addr));
  assign imem_rdata = mem_addr ^ 16'hBEEF;

  always @(posedge clk) begin
    if (rst) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= 16'h0;
    end else if (imem_req) begin
      mem_pend <= 1'b1;
      mem_addr <= imem_addr;
      mem_cnt  <= lat;
    end else if (imem_ack) begin
      mem_pend <= 1'b0;
    end else if (mem_pend && mem_cnt > 1) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  // Logs of issued addresses and consumed entries, sampled mid-cycle.
  logic [15:0] req_log[$];
  logic [15:0] pc2_log[$];
  logic [15:0] ins_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req) req_log.push_back(imem_addr);
      if (out_valid && out_ready) begin
        pc2_log.push_back(out_pc2);
        ins_log.push_back(out_instr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [15:0] q[$], input int i);
    if (i < q.size()) return {16'h0, q[i]};
    return 32'hDEAD_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pc2_log.delete();
    ins_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; out_ready = 1'b0;

    // Reset state and sequential fetch with 2-cycle memory
    lat = 2;
    tick(); tick();
    check("rst_req",   {31'h0, imem_req},  32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_instr", {16'h0, out_instr}, 32'h0);
    check("rst_pc2",   {16'h0, out_pc2},   32'h0);
    check("rst_err",   {31'h0, err},       32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    clear_logs();
    run(20);
    check("seq_addr0", qat(req_log, 0), 32'h0000);
    check("seq_addr1", qat(req_log, 1), 32'h0002);
    check("seq_addr2", qat(req_log, 2), 32'h0004);
    check("seq_pc2_0", qat(pc2_log, 0), 32'h0002);
    check("seq_pc2_1", qat(pc2_log, 1), 32'h0004);
    check("seq_pc2_2", qat(pc2_log, 2), 32'h0006);
    check("seq_ins0",  qat(ins_log, 0), 32'h0000 ^ 32'hBEEF);
    check("seq_err",   {31'h0, err},    32'h0);

    // Backpressure: queue fills, exactly four requests, one pop frees one slot
    out_ready = 1'b0;
    lat = 1;
    do_reset();
    clear_logs();
    run(30);
    check("full_nreq",  req_log.size(),     32'd4);
    check("full_req",   {31'h0, imem_req},  32'h0);
    check("full_valid", {31'h0, out_valid}, 32'h1);
    check("full_head",  {16'h0, out_pc2},   32'h0002);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run(10);
    check("pop_pc2",   qat(pc2_log, 0),   32'h0002);
    check("pop_npop",  pc2_log.size(),    32'd1);
    check("pop_nreq",  req_log.size(),    32'd5);
    check("pop_addr",  qat(req_log, 4),   32'h0008);
    check("pop_head",  {16'h0, out_pc2},  32'h0004);

    // Redirect while waiting on 0x0006: response discarded, restart at 0x0100
    lat = 1;
    hold_en = 1'b1;
    hold_addr = 16'h0006;
    do_reset();
    clear_logs();
    run(15);
    check("rd_nreq",  req_log.size(),    32'd4);
    check("rd_last",  qat(req_log, 3),   32'h0006);
    check("rd_valid", {31'h0, out_valid}, 32'h1);
    clear_logs();
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    check("rd_flush", {31'h0, out_valid}, 32'h0);
    check("rd_noreq", {31'h0, imem_req},  32'h0);
    hold_en = 1'b0;
    out_ready = 1'b1;
    run(10);
    check("rd_addr", qat(req_log, 0), 32'h0100);
    check("rd_pc2",  qat(pc2_log, 0), 32'h0102);
    check("rd_ins",  qat(ins_log, 0), 32'h0100 ^ 32'hBEEF);

    // Misaligned redirect: sticky error, no further requests, rst clears
    out_ready = 1'b1;
    lat = 1;
    do_reset();
    run(6);
    redirect = 1'b1;
    redirect_pc = 16'h0101;
    tick();
    redirect = 1'b0;
    check("mis_err", {31'h0, err}, 32'h1);
    clear_logs();
    run(20);
    check("mis_sticky", {31'h0, err},       32'h1);
    check("mis_nreq",   req_log.size(),     32'd0);
    check("mis_valid",  {31'h0, out_valid}, 32'h0);
    rst = 1'b1;
    tick();
    check("mis_clr", {31'h0, err}, 32'h0);
    tick();
    rst = 1'b0;

    // PC wrap: fetch at 0xFFFE gives pc2 0x0000 and next address 0x0000
    out_ready = 1'b1;
    clear_logs();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    run(10);
    check("wrap_a0",  qat(req_log, 0), 32'hFFFE);
    check("wrap_a1",  qat(req_log, 1), 32'h0000);
    check("wrap_pc2", qat(pc2_log, 0), 32'h0000);
    check("wrap_ins", qat(ins_log, 0), 32'h4111);

    // Halt during WAIT: in-flight response still lands, resume afterwards
    out_ready = 1'b1;
    lat = 3;
    do_reset();
    clear_logs();
    for (int i = 0; i < 50 && req_log.size() < 2; i++) tick();
    check("halt_reach", req_log.size(), 32'd2);
    halt = 1'b1;
    run(20);
    check("halt_nreq", req_log.size(),    32'd2);
    check("halt_req",  {31'h0, imem_req}, 32'h0);
    check("halt_npop", pc2_log.size(),    32'd2);
    check("halt_pc2",  qat(pc2_log, 1),   32'h0004);
    halt = 1'b0;
    run(10);
    check("halt_resume", qat(req_log, 2), 32'h0004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/infetch_queue.md
Name:
infetch_queue

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Owns the PC and issues one outstanding request at a time to a variable-latency instruction memory (req/ack handshake).
- Buffers returned instructions with their PC+INC in a DEPTH-entry FIFO, and presents them to decode with valid/ready.
- Accepts redirects (branch/jump/JR targets resolved downstream) and halt, squashing any stale in-flight fetch.

Parameters:
WIDTH, 16, PC/address and instruction width in bits
DEPTH, 4, instruction queue entries (power of two, >=2)
INC, 2, PC increment per instruction
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
halt  input  1  stop issuing new fetches while high
redirect  input  1  load redirect_pc, flush queue, squash in-flight fetch
redirect_pc  input  WIDTH  redirect target
imem_req  output  1  fetch request valid
imem_addr  output  WIDTH  fetch address (valid while imem_req)
imem_ack  input  1  memory response valid, 1-cycle pulse per request
imem_rdata  input  WIDTH  returned instruction (valid with imem_ack)
out_valid  output  1  queue head valid
out_ready  input  1  decode accepts head
out_instr  output  WIDTH  head instruction
out_pc2  output  WIDTH  head address + INC
err  output  1  sticky misaligned-redirect error

Behaviour:
- Reset: PC=RESET_PC, queue empty (count=0), state IDLE, squash=0, err=0, imem_req=0, out_valid=0, out_instr=0, out_pc2=0.
- States:
  - IDLE: goes to REQ when !halt && !err && (count + 0) < DEPTH.
  - REQ: imem_req=1, imem_addr=PC; the request is accepted on the same edge, so next state is WAIT.
  - WAIT: imem_req=0; on imem_ack:
    - if !squash, push {imem_rdata, PC+INC} and set PC=PC+INC;
    - clear squash;
    - next state is REQ if the issue condition still holds, else IDLE.
- Issue condition: !halt && !err && count < DEPTH, with count evaluated after this cycle's push/pop. This guarantees space for the outstanding response.
- Only one request is ever outstanding; imem_ack outside WAIT is ignored.
- Output handshake:
  - out_valid = (count != 0).
  - Pop when out_valid && out_ready.
  - out_instr/out_pc2 are the head entry; they hold stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged. Push with full queue cannot occur.
- Wrap-around:
  - PC arithmetic is modulo 2^WIDTH (0xFFFE + 2 = 0x0000).
  - Queue pointers wrap modulo DEPTH.
- Redirect (highest priority, overrides ack push and pop in the same cycle):
  - PC=redirect_pc; queue flushed (count=0, pointers reset), out_valid=0 next cycle.
  - If in WAIT, set squash=1 and stay in WAIT; the pending response is discarded.
  - If in REQ, that request becomes in-flight, so set squash=1 and go to WAIT.
  - If in IDLE, go to REQ next cycle when the issue condition holds.
- Misalignment: redirect with redirect_pc[0]=1 (INC=2) sets err=1 sticky until rst. Once err is set, no new requests; the queue still drains.
- Halt: blocks new requests only. An in-flight request completes and is pushed. The queue keeps draining. Deasserting halt resumes at the current PC.
- rst mid-operation: the state returns to reset values immediately. A late imem_ack after reset (in IDLE) is ignored.

Optional Feature:
- Macro: INFETCH_BYPASS_EN.
- Defined: when count==0 and imem_ack && !squash && !redirect, imem_rdata/PC+INC drive the outputs combinationally with out_valid=1 that same cycle. If out_ready=1, the entry is consumed without being pushed; otherwise it is pushed normally.
- Undefined: a returned instruction is visible on the outputs no earlier than the cycle after imem_ack (minimum ack-to-out_valid latency of 1).

Test Plan:
- Reset, RESET_PC=0, memory with 2-cycle ack latency, out_ready=1 -> imem_addr sequence 0x0000,0x0002,0x0004; out_pc2 sequence 0x0002,0x0004,0x0006; err=0.
- out_ready=0 with 1-cycle memory, DEPTH=4 -> exactly 4 requests issued, then imem_req stays 0. Raising out_ready for 1 cycle pops the head (pc2 0x0002) and re-enables exactly one request (addr 0x0008).
- Redirect to 0x0100 while in WAIT for addr 0x0006 -> the 0x0006 response is discarded, the queue is empty next cycle, the next imem_addr is 0x0100, and the first out_pc2 is 0x0102.
- Redirect to 0x0101 -> err=1 next cycle and stays 1. No further imem_req; the queued entries still pop. rst clears err.
- PC=0xFFFE fetch -> out_pc2=0x0000, next imem_addr=0x0000.
- halt raised during WAIT -> the response is pushed, no new imem_req while halt=1; after halt falls, fetch resumes at the next sequential address.
